// File: rtl/host_mem_cycle_timer.sv
// Host-side support block: a free-running cycle counter used as a timebase
// for timeout checks, plus a single-port synchronous memory with per-byte
// write enables that tiles reach over the network. The two share clock and
// reset but are otherwise independent.
module host_mem_cycle_timer #(
    parameter int unsigned                ctr_width_p    = 40,
    parameter logic [ctr_width_p-1:0]     ctr_init_val_p = '0,
    parameter int unsigned                data_width_p   = 32,
    parameter int unsigned                els_p          = 2**18,
    localparam int unsigned               mask_width_lp  = data_width_p / 8,
    localparam int unsigned               addr_width_lp  = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    output logic [ctr_width_p-1:0]        ctr_r_o,

    input  logic                          v_i,
    input  logic                          w_i,
    input  logic [addr_width_lp-1:0]      addr_i,
    input  logic [data_width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0]      write_mask_i,
    output logic [data_width_p-1:0]       data_o
);

    logic [data_width_p-1:0] mem [els_p];

    logic addr_ok;
    logic wr_en;
    logic rd_en;

    // When els_p is a power of two every encodable address is in range, so
    // the comparison is elided to keep it from degenerating to a constant.
    if (els_p == (2**addr_width_lp)) begin : g_full_range
        assign addr_ok = 1'b1;
    end else begin : g_partial_range
        assign addr_ok = ({1'b0, addr_i} < (addr_width_lp + 1)'(els_p));
    end

    assign wr_en = v_i &  w_i & addr_ok;
    assign rd_en = v_i & ~w_i;

    // Free-running cycle counter; wraps modulo 2^ctr_width_p without a flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_r_o <= ctr_init_val_p;
        end else begin
            ctr_r_o <= ctr_r_o + ctr_width_p'(1);
        end
    end

    // Byte-masked write; storage is never reset, and accesses presented
    // while reset is held are ignored so earlier contents survive reset.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && wr_en) begin
            for (int unsigned k = 0; k < mask_width_lp; k++) begin
                if (write_mask_i[k]) begin
                    mem[addr_i][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    // Registered read port: loads only on reads, holds on idle and write
    // cycles; out-of-range reads return zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o <= '0;
        end else if (rd_en) begin
            data_o <= addr_ok ? mem[addr_i] : '0;
        end
    end

endmodule

// File: tb/tb_host_mem_cycle_timer.sv
// Self-checking bench for host_mem_cycle_timer: two instances with different
// counter widths/initial values share one memory-access stimulus stream and
// are compared against a behavioural model kept in this file.
module tb_host_mem_cycle_timer;

    localparam int unsigned DW    = 32;
    localparam int unsigned ELS   = 1000;
    localparam int unsigned AW    = 10;
    localparam int unsigned MW    = DW / 8;
    localparam int unsigned CW_A  = 6;
    localparam int unsigned INIT_A = 0;
    localparam int unsigned CW_B  = 4;
    localparam int unsigned INIT_B = 9;

    logic              clk_i;
    logic              reset_n_i;
    logic              v_i;
    logic              w_i;
    logic [AW-1:0]     addr_i;
    logic [DW-1:0]     data_i;
    logic [MW-1:0]     write_mask_i;
    logic [CW_A-1:0]   ctr_a;
    logic [CW_B-1:0]   ctr_b;
    logic [DW-1:0]     dout_a;
    logic [DW-1:0]     dout_b;

    host_mem_cycle_timer #(
        .ctr_width_p    (CW_A),
        .ctr_init_val_p (6'(INIT_A)),
        .data_width_p   (DW),
        .els_p          (ELS)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .ctr_r_o      (ctr_a),
        .v_i          (v_i),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .write_mask_i (write_mask_i),
        .data_o       (dout_a)
    );

    host_mem_cycle_timer #(
        .ctr_width_p    (CW_B),
        .ctr_init_val_p (4'(INIT_B)),
        .data_width_p   (DW),
        .els_p          (ELS)
    ) dut_narrow (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .ctr_r_o      (ctr_b),
        .v_i          (v_i),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .write_mask_i (write_mask_i),
        .data_o       (dout_b)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Behavioural model: memory words with per-byte "known" flags, the
    // number of clock edges seen since reset release, and the read register.
    logic [DW-1:0] mref   [ELS];
    logic [MW-1:0] mknown [ELS];
    int unsigned   edges;
    logic [DW-1:0] mdout;
    bit            mdout_known;

    function automatic longint unsigned exp_ctr(int unsigned width, int unsigned init);
        return (longint'(init) + longint'(edges)) % (longint'(1) << width);
    endfunction

    // Apply the memory rules for one rising edge using the inputs as presented.
    task automatic model_edge();
        int unsigned a;
        a = int'(addr_i);
        edges++;
        if (v_i && w_i) begin
            if (a < ELS) begin
                for (int k = 0; k < MW; k++) begin
                    if (write_mask_i[k]) begin
                        mref[a][8*k +: 8] = data_i[8*k +: 8];
                        mknown[a][k] = 1'b1;
                    end
                end
            end
        end else if (v_i) begin
            if (a < ELS) begin
                mdout       = mref[a];
                mdout_known = (mknown[a] == '1);
            end else begin
                mdout       = '0;
                mdout_known = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        edges       = 0;
        mdout       = '0;
        mdout_known = 1'b1;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (reset_n_i) model_edge();
        else           model_reset();
    endtask

    task automatic drive(input logic v, input logic w, input int unsigned a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        v_i          = v;
        w_i          = w;
        addr_i       = AW'(a);
        data_i       = d;
        write_mask_i = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b1;
        idle();
        #2 reset_n_i = 1'b0;
        model_reset();
        drive(1'b1, 1'b1, 7, 32'h0BAD_0BAD, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ctr_a !== CW_A'(INIT_A) || ctr_b !== CW_B'(INIT_B)) begin
                fails++;
                $display("FAIL reset_ctr cycle %0d: got %0d/%0d want %0d/%0d", i, ctr_a, ctr_b, INIT_A, INIT_B);
            end
            checks++;
            if (dout_a !== '0 || dout_b !== '0) begin
                fails++;
                $display("FAIL reset_dout cycle %0d: got %h/%h want 0", i, dout_a, dout_b);
            end
        end
        idle();
        reset_n_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (ctr_a !== CW_A'(i) || ctr_b !== CW_B'((INIT_B + i) % 16)) begin
                fails++;
                $display("FAIL release_ctr step %0d: got %0d/%0d want %0d/%0d", i, ctr_a, ctr_b, i, (INIT_B + i) % 16);
            end
        end
    endtask

    task automatic test_counter_wrap();
        idle();
        for (int i = 0; i < 70; i++) begin
            tick();
            checks++;
            if (ctr_a !== CW_A'(exp_ctr(CW_A, INIT_A)) || ctr_b !== CW_B'(exp_ctr(CW_B, INIT_B))) begin
                fails++;
                $display("FAIL counter_wrap edge %0d: got %0d/%0d want %0d/%0d", edges, ctr_a, ctr_b,
                         exp_ctr(CW_A, INIT_A), exp_ctr(CW_B, INIT_B));
            end
        end
    endtask

    task automatic test_full_write_read();
        drive(1'b1, 1'b1, 'h10, 32'hDEAD_BEEF, 4'hF);
        tick();
        drive(1'b1, 1'b0, 'h10, 32'h0, 4'h0);
        tick();
        idle();
        checks++;
        if (dout_a !== 32'hDEAD_BEEF || dout_b !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL full_write_read: got %h/%h want deadbeef", dout_a, dout_b);
        end
    endtask

    task automatic test_partial_mask();
        drive(1'b1, 1'b1, 'h10, 32'h1122_3344, 4'b0101);
        tick();
        drive(1'b1, 1'b0, 'h10, 32'hFFFF_FFFF, 4'hF);
        tick();
        idle();
        checks++;
        if (dout_a !== 32'hDE22_BE44 || dout_a !== mdout) begin
            fails++;
            $display("FAIL partial_mask: got %h want de22be44", dout_a);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 'h20, 32'hCAFE_F00D, 4'hF);
        tick();
        drive(1'b1, 1'b0, 'h20, '0, '0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout_a !== 32'hCAFE_F00D) begin
                fails++;
                $display("FAIL hold_idle %0d: got %h want cafef00d", i, dout_a);
            end
        end
        drive(1'b1, 1'b1, 'h21, 32'h1234_5678, 4'hF);
        tick();
        checks++;
        if (dout_a !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL hold_write: got %h want cafef00d", dout_a);
        end
        drive(1'b1, 1'b1, 5, 32'h5555_AAAA, 4'hF);
        tick();
        drive(1'b1, 1'b0, 5, '0, '0);
        tick();
        idle();
        checks++;
        if (dout_a !== 32'h5555_AAAA) begin
            fails++;
            $display("FAIL write_then_read: got %h want 5555aaaa", dout_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 32'hA;
        vals[1] = 32'hB;
        vals[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, i + 1, vals[i], 4'hF);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, i + 1, '0, '0);
            tick();
            checks++;
            if (dout_a !== vals[i] || dout_b !== vals[i]) begin
                fails++;
                $display("FAIL pipelined_read addr %0d: got %h/%h want %h", i + 1, dout_a, dout_b, vals[i]);
            end
        end
        idle();
    endtask

    task automatic test_boundary();
        drive(1'b1, 1'b1, ELS - 1, 32'h7E57_0FF1, 4'hF);
        tick();
        drive(1'b1, 1'b1, ELS - 1, 32'hFFFF_FFFF, 4'h0);
        tick();
        drive(1'b1, 1'b0, ELS - 1, '0, '0);
        tick();
        checks++;
        if (dout_a !== 32'h7E57_0FF1) begin
            fail_line("top_addr_mask0", dout_a, 32'h7E57_0FF1);
        end
        drive(1'b1, 1'b1, ELS, 32'h0000_0001, 4'hF);
        tick();
        drive(1'b1, 1'b1, 1023, 32'h0000_0002, 4'hF);
        tick();
        drive(1'b1, 1'b0, ELS, '0, '0);
        tick();
        checks++;
        if (dout_a !== '0 || dout_b !== '0) begin
            fail_line("out_of_range_read", dout_a, '0);
        end
        drive(1'b1, 1'b0, ELS - 1, '0, '0);
        tick();
        idle();
        checks++;
        if (dout_a !== 32'h7E57_0FF1) begin
            fail_line("oor_write_dropped", dout_a, 32'h7E57_0FF1);
        end
    endtask

    task automatic fail_line(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        fails++;
        $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic test_async_reset();
        reset_n_i = 1'b0;
        idle();
        tick();
        reset_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < 36; i++) tick();
        drive(1'b1, 1'b0, 'h10, '0, '0);
        tick();
        checks++;
        if (ctr_a !== CW_A'(37) || dout_a !== 32'hDE22_BE44) begin
            fails++;
            $display("FAIL pre_async_reset: got ctr %0d dout %h want 37 de22be44", ctr_a, dout_a);
        end
        drive(1'b1, 1'b1, 'h10, 32'h0, 4'hF);
        #2 reset_n_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ctr_a !== CW_A'(INIT_A) || ctr_b !== CW_B'(INIT_B) || dout_a !== '0 || dout_b !== '0) begin
            fails++;
            $display("FAIL async_reset: got ctr %0d/%0d dout %h want %0d/%0d 0", ctr_a, ctr_b, dout_a, INIT_A, INIT_B);
        end
        tick();
        idle();
        reset_n_i = 1'b1;
        drive(1'b1, 1'b0, 'h10, '0, '0);
        tick();
        idle();
        checks++;
        if (dout_a !== 32'hDE22_BE44) begin
            fail_line("mem_retained", dout_a, 32'hDE22_BE44);
        end
        checks++;
        if (ctr_a !== CW_A'(1) || ctr_b !== CW_B'(INIT_B + 1)) begin
            fails++;
            $display("FAIL post_async_ctr: got %0d/%0d want 1/%0d", ctr_a, ctr_b, INIT_B + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(ELS, 1023) : $urandom_range(0, 63),
                  $urandom, MW'($urandom));
            tick();
            checks++;
            if (ctr_a !== CW_A'(exp_ctr(CW_A, INIT_A)) || ctr_b !== CW_B'(exp_ctr(CW_B, INIT_B))) begin
                fails++;
                $display("FAIL random_ctr %0d: got %0d/%0d want %0d/%0d", i, ctr_a, ctr_b,
                         exp_ctr(CW_A, INIT_A), exp_ctr(CW_B, INIT_B));
            end
            if (mdout_known) begin
                checks++;
                if (dout_a !== mdout || dout_b !== mdout) begin
                    fails++;
                    $display("FAIL random_dout %0d: got %h/%h want %h", i, dout_a, dout_b, mdout);
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < ELS; i++) begin
            mref[i]   = '0;
            mknown[i] = '0;
        end
        model_reset();
        test_reset();
        test_counter_wrap();
        test_full_write_read();
        test_partial_mask();
        test_hold();
        test_back_to_back();
        test_boundary();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
